// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Package : dds_pkg
// Brief   : Shared FSM encodings, channel widths and helpers for DDS output prep.
// Rev     : 1.0  initial release
// ============================================================================
package dds_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int FREQ_W  = 48;
    localparam int PHASE_W = 14;
    localparam int AMP_W   = 10;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

    function automatic int dds_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_opp_clamp.sv
`default_nettype none
// ============================================================================
// Module : dds_opp_clamp
// Brief  : Clamps a signed wide sum into an unsigned [min, max] window.
// Rev    : 1.0  initial release
// ============================================================================
module dds_opp_clamp #(
    parameter int SUM_W = 52,
    parameter int OUT_W = 48
) (
    input  logic signed [SUM_W-1:0] sum_i,
    input  logic        [OUT_W-1:0] min_i,
    input  logic        [OUT_W-1:0] max_i,
    output logic        [OUT_W-1:0] word_o
);

    localparam int PAD_W = SUM_W - OUT_W;

    logic signed [SUM_W-1:0] w_min_ext;
    logic signed [SUM_W-1:0] w_max_ext;

    // Zero-extended bounds are always non-negative, so negative sums fall below min.
    assign w_min_ext = $signed({{PAD_W{1'b0}}, min_i});
    assign w_max_ext = $signed({{PAD_W{1'b0}}, max_i});

    always_comb begin
        word_o = sum_i[OUT_W-1:0];
        if (sum_i < w_min_ext) begin
            word_o = min_i;
        end else if (sum_i > w_max_ext) begin
            word_o = max_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds_output_prep.sv
`default_nettype none
// ============================================================================
// Module : dds_output_prep
// Brief  : Scales a signed PID sample, offsets, clamps and hands one control
//          word per write to the DDS serial controller. Define
//          DDS_OPP_TIMEOUT_EN to add a write-complete timeout and timeout_out.
// Rev    : 1.0  initial release
// ============================================================================
module dds_output_prep
    import dds_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int MULT_W = 16,
    parameter int OUT_W  = 48
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dv_in,
    input  logic              lock_en_in,
    input  logic [OUT_W-1:0]  init_in,
    input  logic [MULT_W-1:0] mult_in,
    input  logic [5:0]        rs_in,
    input  logic [OUT_W-1:0]  min_in,
    input  logic [OUT_W-1:0]  max_in,
    input  logic              wr_done_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              dv_out,
    output logic              busy_out
`ifdef DDS_OPP_TIMEOUT_EN
    ,
    output logic              timeout_out
`endif
);

    localparam int PROD_W = DATA_W + MULT_W;
    localparam int SUM_W  = dds_max(OUT_W, PROD_W) + 2;

    logic [DATA_W-1:0]        in_data_q;
    logic                     in_v_q;
    logic signed [PROD_W-1:0] prod_q;
    logic                     v1_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     v2_q;

    logic [PROD_W-1:0]        w_data_ext;
    logic [PROD_W-1:0]        w_mult_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;
    logic signed [SUM_W-1:0]  w_sum;
    logic [OUT_W-1:0]         w_clamp;

    logic [OUT_W-1:0]         pend_q, pend_d;
    logic                     pend_v_q, pend_v_d;
    logic [1:0]               state_q, state_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic                     dv_q;
    logic                     busy_q;
    logic                     w_done;

`ifdef DDS_OPP_TIMEOUT_EN
    logic [15:0]              cnt_q, cnt_d;
    logic                     timeout_q, timeout_d;
`endif

    assign w_data_ext = {{MULT_W{in_data_q[DATA_W-1]}}, in_data_q};
    assign w_mult_ext = {{DATA_W{mult_in[MULT_W-1]}}, mult_in};
    assign w_prod     = $signed(w_data_ext) * $signed(w_mult_ext);
    assign w_shift    = prod_q >>> rs_in;
    assign w_sum      = $signed({{(SUM_W-OUT_W){1'b0}}, init_in})
                      + $signed({{(SUM_W-PROD_W){w_shift[PROD_W-1]}}, w_shift});

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            in_data_q <= '0;
            in_v_q    <= 1'b0;
            prod_q    <= '0;
            v1_q      <= 1'b0;
            sum_q     <= '0;
            v2_q      <= 1'b0;
        end else begin
            in_v_q <= dv_in;
            v1_q   <= in_v_q;
            v2_q   <= v1_q;
            if (dv_in) begin
                in_data_q <= data_in;
            end
            if (in_v_q) begin
                prod_q <= lock_en_in ? w_prod : '0;
            end
            if (v1_q) begin
                sum_q <= w_sum;
            end
        end
    end

    dds_opp_clamp #(
        .SUM_W (SUM_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .sum_i  (sum_q),
        .min_i  (min_in),
        .max_i  (max_in),
        .word_o (w_clamp)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        data_d   = data_q;
        w_done   = wr_done_in;
`ifdef DDS_OPP_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        if (v2_q) begin
            pend_d = w_clamp;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                pend_v_d = 1'b0;
                state_d  = ST_WAIT;
`ifdef DDS_OPP_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            ST_WAIT: begin
`ifdef DDS_OPP_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
                if (!wr_done_in && (cnt_q == TIMEOUT_LIMIT)) begin
                    timeout_d = 1'b1;
                    w_done    = 1'b1;
                end
`endif
                if (w_done) begin
                    state_d = (pend_v_q || v2_q) ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh stage-3 result outranks the clear done while sending.
        if (v2_q) begin
            pend_v_d = 1'b1;
        end
        if (state_d == ST_SEND) begin
            data_d = pend_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            state_q  <= state_d;
            data_q   <= data_d;
            dv_q     <= (state_d == ST_SEND);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

`ifdef DDS_OPP_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`endif

    assign data_out = data_q;
    assign dv_out   = dv_q;
    assign busy_out = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_output_prep.sv
`default_nettype none
// ============================================================================
// Module : tb_dds_output_prep
// Brief  : Directed self-checking bench for the 14-bit (phase) channel.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dds_output_prep;

    localparam int DATA_W = 18;
    localparam int MULT_W = 16;
    localparam int OUT_W  = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              dv_in = 1'b0;
    logic              lock_en = 1'b1;
    logic [OUT_W-1:0]  init_v = '0;
    logic [MULT_W-1:0] mult_v = '0;
    logic [5:0]        rs_v = '0;
    logic [OUT_W-1:0]  min_v = '0;
    logic [OUT_W-1:0]  max_v = '0;
    logic              wr_done = 1'b0;
    logic [OUT_W-1:0]  data_out;
    logic              dv_out;
    logic              busy_out;
`ifdef DDS_OPP_TIMEOUT_EN
    logic              timeout_out;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (dv_out) pulses++;

    dds_output_prep #(
        .DATA_W (DATA_W),
        .MULT_W (MULT_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .data_in    (data_in),
        .dv_in      (dv_in),
        .lock_en_in (lock_en),
        .init_in    (init_v),
        .mult_in    (mult_v),
        .rs_in      (rs_v),
        .min_in     (min_v),
        .max_in     (max_v),
        .wr_done_in (wr_done),
        .data_out   (data_out),
        .dv_out     (dv_out),
        .busy_out   (busy_out)
`ifdef DDS_OPP_TIMEOUT_EN
        ,
        .timeout_out (timeout_out)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic lk, input int init, input int mult, input int rs,
                       input int mn, input int mx);
        lock_en = lk;
        init_v  = OUT_W'(init);
        mult_v  = MULT_W'(mult);
        rs_v    = 6'(rs);
        min_v   = OUT_W'(mn);
        max_v   = OUT_W'(mx);
    endtask

    // Returns at the negedge of the dv_out cycle; lat counts edges after the sampling edge.
    task automatic send_wait(input int d, output int lat, output logic ok);
        @(negedge clk);
        data_in = DATA_W'(d);
        dv_in   = 1'b1;
        @(posedge clk);
        lat = 0;
        ok  = 1'b0;
        @(negedge clk);
        dv_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dv_out) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic ack();
        @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    task automatic run(input string tag, input int d, input int exp);
        int   lat;
        logic ok;
        send_wait(d, lat, ok);
        chk({tag, "_seen"}, 64'(ok), 64'd1);
        chk(tag, 64'(data_out), 64'(exp));
        ack();
    endtask

    initial begin
        int   lat;
        logic ok;
        int   p0;
        logic seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_dv", 64'(dv_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);

        cfg(1'b1, 100, 1, 0, 0, 16383);
        send_wait(5, lat, ok);
        chk("basic_seen", 64'(ok), 64'd1);
        chk("basic_lat", 64'(lat), 64'd4);
        chk("basic_data", 64'(data_out), 64'd105);
        chk("basic_busy_send", 64'(busy_out), 64'd1);
        ack();
        chk("basic_busy_idle", 64'(busy_out), 64'd0);

        cfg(1'b1, 100, 1, 0, 0, 1000);
        run("clamp_max", 2000, 1000);
        cfg(1'b1, 100, 1, 0, 0, 16383);
        run("clamp_neg", -200, 0);
        cfg(1'b1, 0, 1, 0, 7, 16383);
        run("clamp_min", -1, 7);
        cfg(1'b1, 1000, -3, 2, 0, 16383);
        run("scale", 40, 970);
        cfg(1'b1, 1000, 5, 63, 0, 16383);
        run("rs63", -1, 999);

        // Two samples land while waiting; only the newer one must go out.
        cfg(1'b1, 100, 1, 0, 0, 16383);
        @(posedge clk);
        p0 = pulses;
        send_wait(1, lat, ok);
        chk("bp_first", 64'(data_out), 64'd101);
        @(negedge clk);
        data_in = DATA_W'(2);
        dv_in   = 1'b1;
        @(negedge clk);
        data_in = DATA_W'(3);
        @(negedge clk);
        dv_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_hold", 64'(data_out), 64'd101);
        chk("bp_busy", 64'(busy_out), 64'd1);
        ack();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dv_out) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_second_seen", 64'(seen), 64'd1);
        chk("bp_last_wins", 64'(data_out), 64'd103);
        ack();
        repeat (5) @(negedge clk);
        @(posedge clk);
        chk("bp_pulses", 64'(pulses - p0), 64'd2);

        cfg(1'b0, 555, 1, 0, 0, 16383);
        run("lock_off", 9999, 555);
        @(posedge clk);
        p0 = pulses;
        ack();
        repeat (8) @(negedge clk);
        @(posedge clk);
        chk("idle_wr_done", 64'(pulses - p0), 64'd0);

        // Reset while waiting with an unsent result pending.
        cfg(1'b1, 100, 1, 0, 0, 16383);
        run("pre_rst", 10, 110);
        send_wait(12, lat, ok);
        @(negedge clk);
        data_in = DATA_W'(11);
        dv_in   = 1'b1;
        @(negedge clk);
        dv_in = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_dv", 64'(dv_out), 64'd0);
        chk("mid_rst_busy", 64'(busy_out), 64'd0);
        @(posedge clk);
        p0 = pulses;
        ack();
        repeat (10) @(negedge clk);
        @(posedge clk);
        chk("post_rst_pulses", 64'(pulses - p0), 64'd0);

`ifdef DDS_OPP_TIMEOUT_EN
        send_wait(20, lat, ok);
        chk("to_send", 64'(data_out), 64'd120);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            lat++;
            if (timeout_out) begin
                seen = 1'b1;
                break;
            end
        end
        chk("timeout_seen", 64'(seen), 64'd1);
        chk("timeout_not_early", 64'(lat >= 65535), 64'd1);
        @(negedge clk);
        chk("timeout_idle", 64'(busy_out), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_output_prep.md
# dds_output_prep

Per-channel output preprocessor that converts signed PID filter samples into unsigned DDS control words (frequency, phase or amplitude) for the DDS serial controller directly downstream. It scales the sample by a signed multiplier and an arithmetic right shift, adds it to an unsigned operating point, clamps the result to a configured window, and issues one data-valid pulse per update. While a write is in flight it holds off, keeping only the newest result until the controller reports write completion. Three instances are used: OUT_W = 48 (frequency), 14 (phase) and 10 (amplitude).

## Interface
- DATA_W, 18: signed input sample width
- MULT_W, 16: signed multiplier width
- OUT_W, 48: unsigned output word width
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- data_in  in  DATA_W  signed PID sample
- dv_in  in  1  sample valid, one-cycle pulse
- lock_en_in  in  1  1: closed loop; 0: output the operating point only
- init_in  in  OUT_W  unsigned operating point
- mult_in  in  MULT_W  signed gain
- rs_in  in  6  arithmetic right-shift amount, 0..63
- min_in  in  OUT_W  lower clamp, unsigned
- max_in  in  OUT_W  upper clamp, unsigned; min_in ≤ max_in required
- wr_done_in  in  1  controller write-complete pulse for this channel
- data_out  out  OUT_W  control word, reset 0
- dv_out  out  1  one-cycle valid pulse, reset 0
- busy_out  out  1  high in ST_SEND and ST_WAIT, reset 0

## Operation
- **Stage 1 (registered):** prod = data_in × mult_in, signed, DATA_W+MULT_W bits. prod is forced to 0 when lock_en_in = 0.
- **Stage 2 (registered):** sum = zero-extended init_in + sign-extended (prod >>> rs_in). SUM_W = max(OUT_W, DATA_W+MULT_W) + 2, so the sum never overflows.
- **Stage 3 (registered):**
  - sum < min_in (including negative sums) → min_in
  - sum > max_in → max_in
  - otherwise → sum[OUT_W-1:0]
  - The result is written into the pending register and sets pend_v.
- Pending register depth is 1. A newer result overwrites an unsent one, so the last sample wins. Dropped results are not counted.
- **FSM states:** ST_IDLE, ST_SEND, ST_WAIT.
  - ST_IDLE: pend_v=1 → ST_SEND.
  - ST_SEND, one cycle: data_out ← pending, dv_out=1, pend_v cleared → ST_WAIT.
  - ST_WAIT: on wr_done_in, go to ST_SEND if pend_v (including a pend_v set that same cycle), else ST_IDLE.
- wr_done_in is ignored in ST_IDLE and ST_SEND.
- In ST_SEND, a stage-3 write on the same cycle as the clear wins: pend_v stays 1.
- data_out holds its value between pulses.
- Configuration inputs are sampled at the stage that uses them. Changes take effect on in-flight samples.
- **rst_in:** pipeline valids, pend_v, FSM (→ ST_IDLE) and all outputs are cleared on the next edge, including mid-wait. No dv_out is issued for pre-reset samples.

## Timing
- dv_in sampled at edge 0 → stage 3 at edge 3 → dv_out high during the cycle after edge 4, when idle. Minimum latency is 4 cycles.
- Back-to-back dv_in is accepted every cycle and the pipeline never stalls. Backpressure is absorbed only by the pending register.
- Sustained throughput is one update per controller write: pulse → ST_WAIT → wr_done_in → ST_SEND next edge.
- dv_out is never asserted twice without an intervening wr_done_in, except after a timeout when DDS_OPP_TIMEOUT_EN is defined.

## Configuration
- **DDS_OPP_TIMEOUT_EN defined:**
  - A 16-bit counter runs in ST_WAIT and clears on entry to ST_WAIT.
  - When it reaches 16'hFFFF without wr_done_in, the FSM leaves ST_WAIT as if wr_done_in had arrived.
  - timeout_out, an extra 1-bit output with reset 0, pulses for one cycle at that point.
- **Undefined:** no counter and no timeout_out port. ST_WAIT waits indefinitely.

## Structure
- Shared package dds_pkg holds:
  - FSM state localparams ST_IDLE/ST_SEND/ST_WAIT (2 bits)
  - channel width constants FREQ_W=48, PHASE_W=14, AMP_W=10
  - timeout limit constant
- Natural sub-module: dds_opp_clamp, holding the stage-3 signed-sum-to-unsigned window clamp with parameters SUM_W and OUT_W.

## Test plan
- **Basic:** OUT_W=14, mult=1, rs=0, init=100, min=0, max=16383, lock=1, data=5 → data_out=105, dv_out exactly 4 cycles after dv_in.
- **Clamp:** max=1000, data=2000 → 1000. data=−200, init=100, min=0 → 0. init=0, data=−1, min=7 → 7.
- **Scaling:** mult=−3, rs=2, init=1000, data=40 → 1000 + (−120>>>2) = 970. Check sign extension at rs=63 with data=−1 → init−1.
- **Backpressure:** first sample emitted, then 2 and 3 arrive in ST_WAIT → after wr_done_in, only 3 emitted. Exactly 2 dv_out pulses in total.
- **Lock off:** lock_en_in=0, init=555, data=9999 → 555. wr_done_in asserted in ST_IDLE → no dv_out.
- **Reset:** rst_in in ST_WAIT with pend_v set → all outputs 0, no dv_out afterwards. With DDS_OPP_TIMEOUT_EN, no wr_done_in → timeout_out pulse after 65535 wait cycles, then ST_IDLE.
